// File: rtl/race_edge_encoder8.sv
// race_edge_encoder8: turns a vector of N binary arrival times into race-logic
// step edges over one 2^TW-cycle window, for the 8-input bitonic edge sorter.
//
// Phases: IDLE (accepting) -> RUN (one priming cycle, then window cycles
// k = 0 .. 2^TW-1 on the registered edges) -> CLEAR (one cycle, edges low,
// window_done high) -> IDLE.
//
// Optional feature macro: RACE_NULL_CODE_EN. When it is defined, the all-ones
// code means "no spike", and that lane stays low for the whole window.
module race_edge_encoder8 #(
  parameter int N  = 8,
  parameter int TW = 3
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [N*TW-1:0] in_times,
  output logic [N-1:0]    edges,
  output logic            window_start,
  output logic            window_done,
  output logic            busy
);

  localparam logic [TW-1:0] K_LAST = '1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    CLEAR = 2'd2
  } state_t;

  state_t          state, state_next;
  logic [TW-1:0]   k, k_next;          // window cycle currently on edges
  logic            live, live_next;    // edges already show a window cycle
  logic [N*TW-1:0] times, times_next;  // holding register, loaded on accept
  logic [N-1:0]    edges_next;
  logic            window_start_next;
  logic            window_done_next;

  // Window index that the edges register shows after the coming clock edge:
  // 0 on the priming cycle, otherwise k+1. Saturates so it never wraps.
  logic [TW-1:0]   k_show;
  logic [N-1:0]    lane_hit;

  // Index that the next registered edges will present.
  always_comb begin
    k_show = '0;
    if (live) begin
      k_show = (k == K_LAST) ? k : k + 1'b1;
    end
  end

  // Per-lane unsigned compare of the held time code against k_show.
  generate
    for (genvar gi = 0; gi < N; gi++) begin : g_lane
      logic [TW-1:0] lane_time;
      assign lane_time = times[gi*TW +: TW];
`ifdef RACE_NULL_CODE_EN
      assign lane_hit[gi] = (lane_time != K_LAST) && (lane_time <= k_show);
`else
      assign lane_hit[gi] = (lane_time <= k_show);
`endif
    end
  endgenerate

  // Handshake and status come straight from the state register.
  assign in_ready = (state == IDLE);
  assign busy     = (state != IDLE);

  // Next-state and next-output logic.
  always_comb begin
    state_next        = state;
    k_next            = k;
    live_next         = live;
    times_next        = times;
    edges_next        = edges;
    window_start_next = 1'b0;
    window_done_next  = 1'b0;

    case (state)
      IDLE: begin
        edges_next = '0;
        if (in_valid) begin
          times_next = in_times;
          k_next     = '0;
          live_next  = 1'b0;
          state_next = RUN;
        end
      end

      RUN: begin
        if (!live) begin
          // Priming cycle: present window cycle k = 0.
          edges_next        = lane_hit;
          window_start_next = 1'b1;
          live_next         = 1'b1;
          k_next            = '0;
        end else if (k == K_LAST) begin
          // Last window cycle is on the outputs; close the window.
          edges_next       = '0;
          window_done_next = 1'b1;
          state_next       = CLEAR;
        end else begin
          k_next     = k_show;
          edges_next = lane_hit;
        end
      end

      CLEAR: begin
        edges_next = '0;
        k_next     = '0;
        live_next  = 1'b0;
        state_next = IDLE;
      end

      default: begin
        edges_next = '0;
        k_next     = '0;
        live_next  = 1'b0;
        state_next = IDLE;
      end
    endcase
  end

  // State, counter and registered outputs; reset clears everything at once.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      k            <= '0;
      live         <= 1'b0;
      times        <= '0;
      edges        <= '0;
      window_start <= 1'b0;
      window_done  <= 1'b0;
    end else begin
      state        <= state_next;
      k            <= k_next;
      live         <= live_next;
      times        <= times_next;
      edges        <= edges_next;
      window_start <= window_start_next;
      window_done  <= window_done_next;
    end
  end

endmodule

// File: tb/tb_race_edge_encoder8.sv
// Testbench for race_edge_encoder8: scoreboard of expected per-cycle outputs
// {in_ready, busy, window_start, window_done, edges}, pushed on acceptance.
module tb_race_edge_encoder8;

  localparam int N  = 8;
  localparam int TW = 3;
  localparam logic [11:0] IDLE_OBS = 12'h800;
  // Lanes 0..7 = {5,0,7,2,2,6,1,3}
  localparam logic [N*TW-1:0] V1 = {3'd3, 3'd1, 3'd6, 3'd2, 3'd2, 3'd7, 3'd0, 3'd5};
  localparam logic [N*TW-1:0] V2 = {3'd6, 3'd2, 3'd7, 3'd4, 3'd1, 3'd0, 3'd3, 3'd3};
`ifdef RACE_NULL_CODE_EN
  localparam logic [7:0] V1_K7 = 8'hFB;
  localparam logic [7:0] ALL7_K7 = 8'h00;
`else
  localparam logic [7:0] V1_K7 = 8'hFF;
  localparam logic [7:0] ALL7_K7 = 8'hFF;
`endif

  logic            clk = 1'b0;
  logic            rst_n;
  logic            in_valid;
  logic            in_ready;
  logic [N*TW-1:0] in_times;
  logic [N-1:0]    edges;
  logic            window_start;
  logic            window_done;
  logic            busy;

  logic [11:0] obs;
  logic [11:0] exp_obs;
  logic [11:0] sb[$];
  int n_cmp = 0;
  int n_fail = 0;
  int cyc = 0;

  race_edge_encoder8 #(.N(N), .TW(TW)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_times(in_times), .edges(edges), .window_start(window_start),
    .window_done(window_done), .busy(busy)
  );

  always #5 clk = ~clk;

  assign obs = {in_ready, busy, window_start, window_done, edges};

  // Reference edge vector for window cycle k.
  function automatic logic [7:0] exp_edges(input logic [N*TW-1:0] t, input int k);
    logic [7:0] e;
    logic [TW-1:0] tv;
    e = '0;
    for (int i = 0; i < N; i++) begin
      tv = t[i*TW +: TW];
`ifdef RACE_NULL_CODE_EN
      e[i] = (int'(tv) <= k) && (tv != 3'd7);
`else
      e[i] = (int'(tv) <= k);
`endif
    end
    return e;
  endfunction

  // Behavioural rank sorter: outputs rise in rank order from the MSB.
  function automatic logic [7:0] sorter_model(input logic [7:0] e);
    int c;
    logic [7:0] ones;
    c = 0;
    for (int i = 0; i < 8; i++) c += int'(e[i]);
    ones = 8'hFF;
    return ~(ones >> c);
  endfunction

  task automatic push_window(input logic [N*TW-1:0] t);
    sb.push_back({1'b0, 1'b1, 1'b0, 1'b0, 8'h00});
    for (int k = 0; k < 8; k++)
      sb.push_back({1'b0, 1'b1, (k == 0), 1'b0, exp_edges(t, k)});
    sb.push_back({1'b0, 1'b1, 1'b0, 1'b1, 8'h00});
  endtask

  // Drive one cycle of stimulus, update the model, advance past the posedge.
  task automatic drive(input logic v, input logic [N*TW-1:0] t);
    @(negedge clk);
    in_valid = v;
    in_times = t;
    if (v && exp_obs[11]) push_window(t);
    @(posedge clk);
    #1;
    exp_obs = (sb.size() > 0) ? sb.pop_front() : IDLE_OBS;
    cyc++;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b0; in_times = '0;
    exp_obs = IDLE_OBS;
    #1;
    n_cmp++;
    if (obs !== IDLE_OBS) begin n_fail++; $display("FAIL reset_hold: got %b want %b", obs, IDLE_OBS); end
    repeat (3) @(posedge clk);
    #1;
    n_cmp++;
    if (obs !== IDLE_OBS) begin n_fail++; $display("FAIL reset_3cyc: got %b want %b", obs, IDLE_OBS); end
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 2; i++) begin
      drive(1'b0, '0);
      n_cmp++;
      if (obs !== exp_obs) begin n_fail++; $display("FAIL reset_release cyc %0d: got %b want %b", cyc, obs, exp_obs); end
    end
    $display("test_reset done at cycle %0d", cyc);
  endtask

  task automatic test_single_window();
    logic [7:0] prev;
    drive(1'b1, V1);
    n_cmp++;
    if (obs !== exp_obs) begin n_fail++; $display("FAIL single_accept: got %b want %b", obs, exp_obs); end
    prev = '0;
    for (int i = 1; i <= 10; i++) begin
      drive(1'b0, '0);
      n_cmp++;
      if (obs !== exp_obs) begin n_fail++; $display("FAIL single_cyc%0d: got %b want %b", i, obs, exp_obs); end
      if (i <= 8) begin
        n_cmp++;
        if ((prev & ~edges) !== 8'h00) begin n_fail++; $display("FAIL single_monotone k=%0d: got %b after %b", i-1, edges, prev); end
        prev = edges;
      end
      if (i == 1) begin
        n_cmp++;
        if ({edges, window_start} !== {8'h02, 1'b1}) begin n_fail++; $display("FAIL single_k0: got edges=%h start=%b want 02/1", edges, window_start); end
      end
      if (i == 3) begin
        n_cmp++;
        if (edges !== 8'h5A) begin n_fail++; $display("FAIL single_k2: got %h want 5a", edges); end
        n_cmp++;
        if (sorter_model(edges) !== 8'hF0) begin n_fail++; $display("FAIL sorter_k2: got %h want f0", sorter_model(edges)); end
      end
      if (i == 8) begin
        n_cmp++;
        if (edges !== V1_K7) begin n_fail++; $display("FAIL single_k7: got %h want %h", edges, V1_K7); end
        n_cmp++;
        if (sorter_model(edges) !== sorter_model(V1_K7)) begin n_fail++; $display("FAIL sorter_k7: got %h want %h", sorter_model(edges), sorter_model(V1_K7)); end
      end
      if (i == 9) begin
        n_cmp++;
        if ({edges, window_done, in_ready} !== {8'h00, 1'b1, 1'b0}) begin n_fail++; $display("FAIL single_clear: got edges=%h done=%b ready=%b", edges, window_done, in_ready); end
      end
      if (i == 10) begin
        n_cmp++;
        if (in_ready !== 1'b1) begin n_fail++; $display("FAIL single_ready10: got %b want 1", in_ready); end
      end
    end
    $display("test_single_window done at cycle %0d", cyc);
  endtask

  task automatic test_backpressure();
    drive(1'b1, V1);
    n_cmp++;
    if (obs !== exp_obs) begin n_fail++; $display("FAIL bp_accept: got %b want %b", obs, exp_obs); end
    for (int i = 1; i <= 21; i++) begin
      drive(1'b1, V2);
      n_cmp++;
      if (obs !== exp_obs) begin n_fail++; $display("FAIL bp_cyc%0d: got %b want %b", i, obs, exp_obs); end
      if (i == 3) begin
        n_cmp++;
        if (edges !== 8'h5A) begin n_fail++; $display("FAIL bp_first_window_k2: got %h want 5a", edges); end
      end
    end
    for (int i = 0; i < 12 && !exp_obs[11]; i++) begin
      drive(1'b0, '0);
      n_cmp++;
      if (obs !== exp_obs) begin n_fail++; $display("FAIL bp_drain cyc %0d: got %b want %b", cyc, obs, exp_obs); end
    end
    $display("test_backpressure done at cycle %0d", cyc);
  endtask

  task automatic test_midwindow_reset();
    drive(1'b1, V1);
    for (int i = 1; i <= 5; i++) begin
      drive(1'b0, '0);
      n_cmp++;
      if (obs !== exp_obs) begin n_fail++; $display("FAIL mid_pre cyc%0d: got %b want %b", i, obs, exp_obs); end
    end
    #2;
    rst_n = 1'b0;
    #1;
    sb.delete();
    exp_obs = IDLE_OBS;
    n_cmp++;
    if (obs !== IDLE_OBS) begin n_fail++; $display("FAIL mid_async_reset: got %b want %b", obs, IDLE_OBS); end
    @(posedge clk);
    #1;
    n_cmp++;
    if (obs !== IDLE_OBS) begin n_fail++; $display("FAIL mid_reset_held: got %b want %b", obs, IDLE_OBS); end
    @(negedge clk);
    rst_n = 1'b1;
    drive(1'b1, '0);
    n_cmp++;
    if (obs !== exp_obs) begin n_fail++; $display("FAIL mid_new_accept: got %b want %b", obs, exp_obs); end
    for (int i = 1; i <= 10; i++) begin
      drive(1'b0, '0);
      n_cmp++;
      if (obs !== exp_obs) begin n_fail++; $display("FAIL mid_new cyc%0d: got %b want %b", i, obs, exp_obs); end
      if (i == 1) begin
        n_cmp++;
        if (edges !== 8'hFF) begin n_fail++; $display("FAIL mid_zero_k0: got %h want ff", edges); end
      end
    end
    $display("test_midwindow_reset done at cycle %0d", cyc);
  endtask

  task automatic test_null_code();
    drive(1'b1, {8{3'd7}});
    for (int i = 1; i <= 10; i++) begin
      drive(1'b0, '0);
      n_cmp++;
      if (obs !== exp_obs) begin n_fail++; $display("FAIL null cyc%0d: got %b want %b", i, obs, exp_obs); end
      if (i == 7) begin
        n_cmp++;
        if (edges !== 8'h00) begin n_fail++; $display("FAIL null_k6: got %h want 00", edges); end
      end
      if (i == 8) begin
        n_cmp++;
        if (edges !== ALL7_K7) begin n_fail++; $display("FAIL null_k7: got %h want %h", edges, ALL7_K7); end
      end
      if (i == 9) begin
        n_cmp++;
        if (window_done !== 1'b1) begin n_fail++; $display("FAIL null_done: got %b want 1", window_done); end
      end
    end
    $display("test_null_code done at cycle %0d", cyc);
  endtask

  task automatic test_back_to_back();
    logic [N*TW-1:0] t;
    for (int i = 0; i < 45; i++) begin
      t = N*TW'($urandom);
      drive(1'b1, t);
      n_cmp++;
      if (obs !== exp_obs) begin n_fail++; $display("FAIL b2b cyc%0d: got %b want %b", i, obs, exp_obs); end
    end
    for (int i = 0; i < 12 && !exp_obs[11]; i++) begin
      drive(1'b0, '0);
      n_cmp++;
      if (obs !== exp_obs) begin n_fail++; $display("FAIL b2b_drain cyc %0d: got %b want %b", cyc, obs, exp_obs); end
    end
    $display("test_back_to_back done at cycle %0d", cyc);
  endtask

  initial begin
    test_reset();
    test_single_window();
    test_backpressure();
    test_midwindow_reset();
    test_null_code();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
    $finish;
  end

endmodule
